// File: rtl/adder_arbiter_if.sv
// Request/response bundle between NREQ requesters and the shared adder arbiter.
// master = requester side, slave = arbiter side.
interface adder_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 32
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [W-1:0]      resp_data;

  modport master (
    output req_valid, req_x, req_y, req_sub, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_x, req_y, req_sub, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one W-bit adder/subtractor among NREQ requesters.
// Defining ADDER_ARBITER_FLAGS_EN adds registered resp_zero/resp_neg/resp_ovf outputs.
module adder_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  adder_arbiter_if.slave bus,
  output logic [W-1:0]   add_x,
  output logic [W-1:0]   add_y,
  output logic           add_sub,
  input  logic [W-1:0]   add_out
`ifdef ADDER_ARBITER_FLAGS_EN
  ,
  output logic           resp_zero,
  output logic           resp_neg,
  output logic           resp_ovf
`endif
);
  localparam int unsigned IdxW = $clog2(NREQ);
  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  state_e          state_q, state_d;
  idx_t            last_grant_q, last_grant_d;
  idx_t            owner_q, owner_d;
  idx_t            grant;
  logic            grant_found;
  logic [W-1:0]    op_x_q, op_x_d, op_y_q, op_y_d, res_q, res_d;
  logic            op_sub_q, op_sub_d;
  logic [NREQ-1:0] req_ready, resp_valid;

  // Scan from the requester after the last grant, wrapping around.
  always_comb begin : grant_pick
    idx_t cand;
    cand        = '0;
    grant       = '0;
    grant_found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = idx_t'((32'(last_grant_q) + k) % NREQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_x_d       = op_x_q;
    op_y_d       = op_y_q;
    op_sub_d     = op_sub_q;
    res_d        = res_q;
    req_ready    = '0;
    resp_valid   = '0;
    unique case (state_q)
      StIdle: begin
        // rst_n gate keeps req_ready low while reset is held.
        if (grant_found && rst_n) begin
          req_ready[grant] = 1'b1;
          op_x_d           = bus.req_x[grant*W +: W];
          op_y_d           = bus.req_y[grant*W +: W];
          op_sub_d         = bus.req_sub[grant];
          owner_d          = grant;
          last_grant_d     = grant;
          state_d          = StCalc;
        end
      end
      StCalc: begin
        res_d   = add_out;
        state_d = StResp;
      end
      StResp: begin
        resp_valid[owner_q] = 1'b1;
        if (bus.resp_ready[owner_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= idx_t'(NREQ - 1);
      owner_q      <= '0;
      op_x_q       <= '0;
      op_y_q       <= '0;
      op_sub_q     <= 1'b0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_x_q       <= op_x_d;
      op_y_q       <= op_y_d;
      op_sub_q     <= op_sub_d;
      res_q        <= res_d;
    end
  end

  assign add_x          = op_x_q;
  assign add_y          = op_y_q;
  assign add_sub        = op_sub_q;
  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = res_q;

`ifdef ADDER_ARBITER_FLAGS_EN
  logic zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

  // Flags share res_q timing: captured from add_out at the end of CALC.
  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    if (state_q == StCalc) begin
      zero_d = (add_out == '0);
      neg_d  = add_out[W-1];
      ovf_d  = (op_sub_q ? (op_x_q[W-1] != op_y_q[W-1]) : (op_x_q[W-1] == op_y_q[W-1]))
               && (add_out[W-1] != op_x_q[W-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
    end
  end

  assign resp_zero = zero_q;
  assign resp_neg  = neg_q;
  assign resp_ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized and directed bench for adder_arbiter against a transaction-level model.
// Flag checks are compiled in when ADDER_ARBITER_FLAGS_EN is defined.
module tb_adder_arbiter;
  localparam int unsigned NREQ = 2;
  localparam int unsigned W    = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] add_x, add_y, add_out;
  logic         add_sub;
`ifdef ADDER_ARBITER_FLAGS_EN
  logic         resp_zero, resp_neg, resp_ovf;
`endif

  adder_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  adder_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_sub   (add_sub),
    .add_out   (add_out)
`ifdef ADDER_ARBITER_FLAGS_EN
    ,
    .resp_zero (resp_zero),
    .resp_neg  (resp_neg),
    .resp_ovf  (resp_ovf)
`endif
  );

  // The adder itself: purely combinational.
  assign add_out = add_sub ? add_x - add_y : add_x + add_y;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase 0 = free, 1 = operation accepted, 2 = result on offer.
  int          m_phase, m_ptr, m_owner, m_accepted, dut_g;
  logic [31:0] m_x, m_y, m_res;
  logic        m_sub, m_zero, m_neg, m_ovf;
  int          waits [NREQ];
  int          dut_grants [$];

  task automatic model_reset();
    m_phase = 0; m_ptr = NREQ - 1; m_owner = 0; m_accepted = -1;
    m_x = '0; m_y = '0; m_sub = 1'b0; m_res = '0;
    m_zero = 1'b0; m_neg = 1'b0; m_ovf = 1'b0;
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (m_ptr + k) % NREQ;
      if (bus.req_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic step();
    int              g;
    logic [NREQ-1:0] exp_rdy;
    longint          s, lim;
    @(negedge clk);
    g       = (m_phase == 0) ? rr_pick() : -1;
    exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
    check_eq("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    check_eq("resp_valid", 64'(bus.resp_valid),
             (m_phase == 2) ? 64'(NREQ'(1) << m_owner) : 64'd0);
    if (m_phase == 2) begin
      check_eq("resp_data", 64'(bus.resp_data), 64'(m_res));
`ifdef ADDER_ARBITER_FLAGS_EN
      check_eq("resp_zero", 64'(resp_zero), 64'(m_zero));
      check_eq("resp_neg", 64'(resp_neg), 64'(m_neg));
      check_eq("resp_ovf", 64'(resp_ovf), 64'(m_ovf));
`endif
    end
    check_eq("add_x", 64'(add_x), 64'(m_x));
    check_eq("add_y", 64'(add_y), 64'(m_y));
    check_eq("add_sub", 64'(add_sub), 64'(m_sub));
    dut_g = -1;
    for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) dut_g = i;
    if (dut_g >= 0) begin
      dut_grants.push_back(dut_g);
      for (int i = 0; i < NREQ; i++) if (i != dut_g && bus.req_valid[i]) waits[i]++;
      check_eq("fairness", 64'(waits[dut_g] <= NREQ - 1), 64'd1);
      waits[dut_g] = 0;
    end
    @(posedge clk);
    m_accepted = -1;
    case (m_phase)
      0: if (g >= 0) begin
        m_x = bus.req_x[g*W +: W]; m_y = bus.req_y[g*W +: W]; m_sub = bus.req_sub[g];
        m_owner = g; m_ptr = g; m_accepted = g; m_phase = 1;
      end
      1: begin
        lim    = 64'sd2147483648;
        s      = m_sub ? longint'($signed(m_x)) - longint'($signed(m_y))
                       : longint'($signed(m_x)) + longint'($signed(m_y));
        m_res  = m_sub ? m_x - m_y : m_x + m_y;
        m_zero = (m_res == 0);
        m_neg  = m_res[31];
        m_ovf  = (s >= lim) || (s < -lim);
        m_phase = 2;
      end
      default: if (bus.resp_ready[m_owner]) m_phase = 0;
    endcase
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check_eq("rst_resp_data", 64'(bus.resp_data), 64'd0);
    check_eq("rst_add_x", 64'(add_x), 64'd0);
    check_eq("rst_add_y", 64'(add_y), 64'd0);
    check_eq("rst_add_sub", 64'(add_sub), 64'd0);
`ifdef ADDER_ARBITER_FLAGS_EN
    check_eq("rst_flags", 64'({resp_zero, resp_neg, resp_ovf}), 64'd0);
`endif
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y, input logic sub);
    bus.req_x[i*W +: W] = x;
    bus.req_y[i*W +: W] = y;
    bus.req_sub[i]      = sub;
    bus.req_valid[i]    = 1'b1;
  endtask

  // Leaves the operation in its response phase.
  task automatic run_op(input int i, input logic [31:0] x, input logic [31:0] y, input logic sub);
    set_req(i, x, y, sub);
    step();
    bus.req_valid[i] = 1'b0;
    step();
  endtask

  task automatic release_resp(input int i);
    bus.resp_ready[i] = 1'b1;
    step();
    bus.resp_ready[i] = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0; bus.req_x = '0; bus.req_y = '0; bus.req_sub = '0; bus.resp_ready = '0;
    model_reset();
    #2 apply_reset();

    // Basic add.
    run_op(0, 32'd5, 32'd7, 1'b0);
    check_eq("t1_resp_valid", 64'(bus.resp_valid), 64'd1);
    check_eq("t1_data", 64'(bus.resp_data), 64'd12);
    release_resp(0);
    check_eq("t1_valid_drop", 64'(bus.resp_valid), 64'd0);

    // 0 - 1 held while resp_ready stays low; non-owner resp_ready ignored.
    run_op(1, 32'd0, 32'd1, 1'b1);
    bus.resp_ready[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_eq("t2_data_hold", 64'(bus.resp_data), 64'hFFFF_FFFF);
      check_eq("t2_valid_hold", 64'(bus.resp_valid), 64'd2);
      step();
    end
`ifdef ADDER_ARBITER_FLAGS_EN
    check_eq("t2_flags", 64'({resp_zero, resp_neg, resp_ovf}), 64'b010);
`endif
    bus.resp_ready[0] = 1'b0;
    release_resp(1);
    check_eq("t2_valid_drop", 64'(bus.resp_valid), 64'd0);

    // Continuous contention: grants alternate starting at 0 after reset.
    apply_reset();
    dut_grants.delete();
    set_req(0, 32'd1, 32'd2, 1'b0);
    set_req(1, 32'd10, 32'd3, 1'b1);
    bus.resp_ready = '1;
    for (int c = 0; c < 15; c++) begin
      step();
      if (m_accepted >= 0) set_req(m_accepted, rand_op(), rand_op(), 1'($urandom));
    end
    check_eq("t3_grant_count", 64'(dut_grants.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < dut_grants.size(); i++)
      check_eq("t3_grant_order", 64'(dut_grants[i]), 64'(i % 2));
    bus.req_valid = '0;
    for (int c = 0; c < 3; c++) step();
    bus.resp_ready = '0;

    // Reset during CALC: operation dropped, a waiting request completes afterwards.
    set_req(0, 32'd3, 32'd4, 1'b0);
    step();
    bus.req_valid[0] = 1'b0;
    set_req(1, 32'd3, 32'd4, 1'b0);
    apply_reset();
    step();
    bus.req_valid[1] = 1'b0;
    step();
    check_eq("t4_resp_owner", 64'(bus.resp_valid), 64'd2);
    check_eq("t4_data", 64'(bus.resp_data), 64'd7);
    release_resp(1);

    // Wrap-around and signed overflow.
    run_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check_eq("t5_wrap", 64'(bus.resp_data), 64'd0);
`ifdef ADDER_ARBITER_FLAGS_EN
    check_eq("t5_wrap_zero", 64'(resp_zero), 64'd1);
    check_eq("t5_wrap_ovf", 64'(resp_ovf), 64'd0);
`endif
    release_resp(0);
    run_op(1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    check_eq("t5_ovf_data", 64'(bus.resp_data), 64'h8000_0000);
`ifdef ADDER_ARBITER_FLAGS_EN
    check_eq("t5_ovf", 64'(resp_ovf), 64'd1);
    check_eq("t5_neg", 64'(resp_neg), 64'd1);
`endif
    release_resp(1);

    // Adder inputs stay on latched operands while another requester's operands churn.
    set_req(0, 32'h1234_5678, 32'h0BAD_F00D, 1'b1);
    step();
    bus.req_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.req_x[1*W +: W] = $urandom;
      bus.req_y[1*W +: W] = $urandom;
      bus.req_sub[1]      = ~bus.req_sub[1];
      #1;
      check_eq("t6_add_x", 64'(add_x), 64'h1234_5678);
      check_eq("t6_add_y", 64'(add_y), 64'h0BAD_F00D);
      check_eq("t6_add_sub", 64'(add_sub), 64'd1);
      step();
    end
    release_resp(0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (m_accepted == i) begin
          if ($urandom_range(0, 1) == 0) bus.req_valid[i] = 1'b0;
          else set_req(i, rand_op(), rand_op(), 1'($urandom));
        end else if (!bus.req_valid[i] && $urandom_range(0, 9) < 4) begin
          set_req(i, rand_op(), rand_op(), 1'($urandom));
        end
      end
      bus.resp_ready = NREQ'($urandom);
    end
    bus.req_valid  = '0;
    bus.resp_ready = '1;
    for (int c = 0; c < 4; c++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
